// File: rtl/decode_pipe_unit.sv
// decode_pipe_unit: registered instruction-decode stage.
// It sits between fetch and register file / ALU / coprocessor issue.
//   upstream   : instruction, in_valid -> in_ready
//   downstream : out_valid -> out_ready, plus the decoded bundle
//                (register addresses, shift amount, immediate, ALU op, mux selects, enables)
//   control    : PC_enable, state (RUN/HALT/TRAP), resume, exc_clear
//   exceptions : coP_* flags qualified by cop_flag_valid, sticky exc_cause
//   stats      : retired_count, a saturating count of accepted non-halt instructions
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | accepting instructions, fetch may advance
// HALT  | opcode 0 seen; wait for resume
// TRAP  | coprocessor exception (TRAP_ON_COP=1); wait for exc_clear
module decode_pipe_unit #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter bit TRAP_ON_COP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        reg1,
  output logic [4:0]        reg2,
  output logic [4:0]        reg3,
  output logic [4:0]        s_r_amount,
  output logic [DATA_W-1:0] im_data,
  output logic [4:0]        alu_opcode,
  output logic [1:0]        jump_mux_signal,
  output logic              write_back_on_register_mux_signal,
  output logic              alu_input_mux_signal,
  output logic              alu_or_coprocessor_mux_signal,
  output logic              register_write_word_enable,
  output logic              register_write_byte_enable,
  output logic              memwrite_enable_a,
  output logic              memwrite_enable_b,
  output logic              memread_enable_a,
  output logic              memread_enable_b,
  output logic              PC_enable,
  input  logic              coP_NaN_flag,
  input  logic              coP_UF_flag,
  input  logic              coP_OF_flag,
  input  logic              coP_Division_by_zero_flag,
  input  logic              cop_flag_valid,
  output logic [3:0]        exc_cause,
  input  logic              exc_clear,
  input  logic              resume,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_HALT = 2'd1, S_TRAP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               out_valid_q;
  logic [3:0]         exc_q, exc_d;
  logic [CNT_W-1:0]   retired_q;

  logic [4:0]         reg1_q, reg2_q, reg3_q, shamt_q, alu_q;
  logic [4:0]         reg1_d, reg2_d, reg3_d, shamt_d, alu_d;
  logic [DATA_W-1:0]  im_q, im_d;
  logic [1:0]         jump_q, jump_d;
  logic               wb_q, wb_d, src_q, src_d, cop_q, cop_d;
  logic               rww_q, rww_d, rwb_q, rwb_d;
  logic               mwa_q, mwa_d, mwb_q, mwb_d, mra_q, mra_d, mrb_q, mrb_d;

  logic [5:0]         opcode;
  logic               halt_op, accept, load, trap_evt;
  logic [3:0]         flags;

  assign opcode   = instruction[31:26];
  assign halt_op  = (opcode == 6'd0);
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && !halt_op;
  assign flags    = {coP_Division_by_zero_flag, coP_OF_flag, coP_UF_flag, coP_NaN_flag};
  assign trap_evt = TRAP_ON_COP && cop_flag_valid && (|flags);

  // Trap outranks a halt opcode accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (trap_evt)                state_d = S_TRAP;
        else if (accept && halt_op)  state_d = S_HALT;
      end
      S_HALT:  if (resume)    state_d = S_RUN;
      S_TRAP:  if (exc_clear) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // A flag report in the clearing cycle survives: clear drops only older causes.
  always_comb begin
    exc_d = exc_q;
    if (exc_clear)           exc_d = cop_flag_valid ? flags : 4'd0;
    else if (cop_flag_valid) exc_d = exc_q | flags;
  end

  always_comb begin
    reg1_d = '0; reg2_d = '0; reg3_d = '0; shamt_d = '0; alu_d = '0;
    im_d   = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    jump_d = '0;
    wb_d = 1'b0; src_d = 1'b0; cop_d = 1'b0; rww_d = 1'b0; rwb_d = 1'b0;
    mwa_d = 1'b0; mwb_d = 1'b0; mra_d = 1'b0; mrb_d = 1'b0;
    if (opcode >= 6'd32 || (opcode >= 6'd1 && opcode <= 6'd15)) begin
      reg3_d  = instruction[25:21];
      reg1_d  = instruction[20:16];
      reg2_d  = instruction[15:11];
      shamt_d = instruction[10:6];
      alu_d   = instruction[30:26];
      wb_d    = 1'b1;
      cop_d   = opcode[5];
      rww_d   = !opcode[5];
      if (!opcode[5]) im_d = '0;
    end else if (opcode >= 6'd16 && opcode <= 6'd23) begin
      reg3_d = instruction[25:21];
      reg1_d = instruction[20:16];
      wb_d   = 1'b1;
      src_d  = 1'b1;
      rww_d  = 1'b1;
      case (instruction[29:26])
        4'd2:    alu_d = 5'd1;
        4'd3:    alu_d = 5'd2;
        4'd4:    alu_d = 5'd3;
        4'd5:    alu_d = 5'd4;
        4'd6:    alu_d = 5'd9;
        4'd7:    alu_d = 5'd10;
        default: alu_d = 5'd0;
      endcase
    end else if (opcode >= 6'd24 && opcode <= 6'd27) begin
      reg1_d = instruction[20:16];
      reg2_d = instruction[25:21];
      reg3_d = instruction[25:21];
      alu_d  = 5'd1;
      src_d  = 1'b1;
      case (opcode[1:0])
        2'd0:    begin rww_d = 1'b1; mra_d = 1'b1; end
        2'd1:    mwa_d = 1'b1;
        2'd2:    begin rwb_d = 1'b1; mrb_d = 1'b1; end
        default: mwb_d = 1'b1;
      endcase
    end else if (opcode >= 6'd28 && opcode <= 6'd31) begin
      reg1_d = instruction[25:21];
      reg2_d = instruction[20:16];
      wb_d   = 1'b1;
      case (opcode[1:0])
        2'd0:    jump_d = 2'd3;
        2'd1:    jump_d = 2'd2;
        2'd2:    begin jump_d = 2'd1; alu_d = 5'd16; end
        default: begin jump_d = 2'd1; alu_d = 5'd15; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN; out_valid_q <= 1'b0; exc_q <= '0; retired_q <= '0;
      reg1_q <= '0; reg2_q <= '0; reg3_q <= '0; shamt_q <= '0; alu_q <= '0;
      im_q <= '0; jump_q <= '0; wb_q <= 1'b0; src_q <= 1'b0; cop_q <= 1'b0;
      rww_q <= 1'b0; rwb_q <= 1'b0;
      mwa_q <= 1'b0; mwb_q <= 1'b0; mra_q <= 1'b0; mrb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      if (load) begin
        out_valid_q <= 1'b1;
        reg1_q <= reg1_d; reg2_q <= reg2_d; reg3_q <= reg3_d; shamt_q <= shamt_d;
        alu_q <= alu_d; im_q <= im_d; jump_q <= jump_d;
        wb_q <= wb_d; src_q <= src_d; cop_q <= cop_d;
        rww_q <= rww_d; rwb_q <= rwb_d;
        mwa_q <= mwa_d; mwb_q <= mwb_d; mra_q <= mra_d; mrb_q <= mrb_d;
        if (retired_q != '1) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (out_ready) begin
        // Drained: side-effecting enables drop, data fields keep their last value.
        out_valid_q <= 1'b0;
        rww_q <= 1'b0; rwb_q <= 1'b0;
        mwa_q <= 1'b0; mwb_q <= 1'b0; mra_q <= 1'b0; mrb_q <= 1'b0;
      end
    end
  end

  assign out_valid                         = out_valid_q;
  assign reg1                              = reg1_q;
  assign reg2                              = reg2_q;
  assign reg3                              = reg3_q;
  assign s_r_amount                        = shamt_q;
  assign im_data                           = im_q;
  assign alu_opcode                        = alu_q;
  assign jump_mux_signal                   = jump_q;
  assign write_back_on_register_mux_signal = wb_q;
  assign alu_input_mux_signal              = src_q;
  assign alu_or_coprocessor_mux_signal     = cop_q;
  assign register_write_word_enable        = rww_q;
  assign register_write_byte_enable        = rwb_q;
  assign memwrite_enable_a                 = mwa_q;
  assign memwrite_enable_b                 = mwb_q;
  assign memread_enable_a                  = mra_q;
  assign memread_enable_b                  = mrb_q;
  assign PC_enable                         = (state_q == S_RUN);
  assign exc_cause                         = exc_q;
  assign state                             = state_q;
  assign retired_count                     = retired_q;

endmodule

// File: tb/tb_decode_pipe_unit.sv
module tb_decode_pipe_unit;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] instruction;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [4:0] reg1, reg2, reg3, s_r_amount, alu_opcode;
  logic [DATA_W-1:0] im_data;
  logic [1:0] jump_mux_signal, state;
  logic wb, alu_src, cop_sel, rww, rwb, mwa, mwb, mra, mrb, PC_enable;
  logic nan_f, uf_f, of_f, dz_f, cop_flag_valid, exc_clear, resume;
  logic [3:0] exc_cause;
  logic [CNT_W-1:0] retired_count;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  decode_pipe_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TRAP_ON_COP(1'b1)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg1(reg1), .reg2(reg2), .reg3(reg3), .s_r_amount(s_r_amount),
    .im_data(im_data), .alu_opcode(alu_opcode), .jump_mux_signal(jump_mux_signal),
    .write_back_on_register_mux_signal(wb), .alu_input_mux_signal(alu_src),
    .alu_or_coprocessor_mux_signal(cop_sel),
    .register_write_word_enable(rww), .register_write_byte_enable(rwb),
    .memwrite_enable_a(mwa), .memwrite_enable_b(mwb),
    .memread_enable_a(mra), .memread_enable_b(mrb),
    .PC_enable(PC_enable),
    .coP_NaN_flag(nan_f), .coP_UF_flag(uf_f), .coP_OF_flag(of_f),
    .coP_Division_by_zero_flag(dz_f), .cop_flag_valid(cop_flag_valid),
    .exc_cause(exc_cause), .exc_clear(exc_clear), .resume(resume),
    .state(state), .retired_count(retired_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instruction = '0; in_valid = 0; out_ready = 0;
    nan_f = 0; uf_f = 0; of_f = 0; dz_f = 0; cop_flag_valid = 0; exc_clear = 0; resume = 0;
    #12;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %0h want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
    tests++; if (PC_enable !== 1'b1) begin failed++; $display("FAIL reset_pc_enable: got %0h want 1", PC_enable); end
    tests++; if (state !== 2'd0) begin failed++; $display("FAIL reset_state: got %0h want 0", state); end
    tests++; if ({retired_count, exc_cause, im_data, reg3, rww, mra} !== '0) begin
      failed++; $display("FAIL reset_fields: got cnt=%0h exc=%0h im=%0h reg3=%0h want all 0", retired_count, exc_cause, im_data, reg3);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_rtype();
    instruction = 32'h0462_2800; in_valid = 1; out_ready = 1;
    step(); in_valid = 0;
    tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL rtype_valid: got %0h want 1", out_valid); end
    tests++; if ({reg3, reg1, reg2} !== {5'd3, 5'd2, 5'd5}) begin
      failed++; $display("FAIL rtype_regs: got %0d/%0d/%0d want 3/2/5", reg3, reg1, reg2);
    end
    tests++; if ({alu_opcode, rww, wb, alu_src, cop_sel} !== {5'd1, 4'b1100}) begin
      failed++; $display("FAIL rtype_ctrl: got alu=%0d rww=%0b wb=%0b src=%0b cop=%0b want 1/1/1/0/0", alu_opcode, rww, wb, alu_src, cop_sel);
    end
    tests++; if (im_data !== 32'd0) begin failed++; $display("FAIL rtype_imm: got %0h want 0", im_data); end
    tests++; if (retired_count !== 4'd1) begin failed++; $display("FAIL rtype_count: got %0d want 1", retired_count); end
    step();
    tests++; if ({out_valid, rww} !== 2'b00) begin failed++; $display("FAIL rtype_drain: got v=%0b rww=%0b want 0/0", out_valid, rww); end
    tests++; if (reg3 !== 5'd3) begin failed++; $display("FAIL rtype_hold_field: got %0d want 3", reg3); end
  endtask

  task automatic test_stall();
    instruction = {6'd18, 5'd7, 5'd4, 16'hFFF0}; in_valid = 1; out_ready = 1;
    step();
    instruction = {6'd2, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0}; out_ready = 0;
    tests++; if ({im_data, alu_opcode, alu_src, rww, reg3, reg1} !== {32'hFFFF_FFF0, 5'd1, 2'b11, 5'd7, 5'd4}) begin
      failed++; $display("FAIL itype_decode: got im=%0h alu=%0d src=%0b rww=%0b rd=%0d rs=%0d want fffffff0/1/1/1/7/4",
                         im_data, alu_opcode, alu_src, rww, reg3, reg1);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({out_valid, in_ready, im_data, alu_opcode} !== {2'b10, 32'hFFFF_FFF0, 5'd1}) begin
        failed++; $display("FAIL stall_hold[%0d]: got v=%0b rdy=%0b im=%0h alu=%0d want 1/0/fffffff0/1", i, out_valid, in_ready, im_data, alu_opcode);
      end
      step();
    end
    out_ready = 1; #1;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL stall_release_ready: got %0b want 1", in_ready); end
    step(); in_valid = 0;
    tests++; if ({out_valid, alu_opcode, reg3, retired_count} !== {1'b1, 5'd2, 5'd1, 4'd3}) begin
      failed++; $display("FAIL stall_next: got v=%0b alu=%0d rd=%0d cnt=%0d want 1/2/1/3", out_valid, alu_opcode, reg3, retired_count);
    end
  endtask

  task automatic test_mem_back_to_back();
    logic [3:0] exp_en [4];
    exp_en[0] = 4'b1000; exp_en[1] = 4'b0100; exp_en[2] = 4'b0010; exp_en[3] = 4'b0001;
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      instruction = {6'(24 + i), 5'd9, 5'd10, 16'h0004};
      step();
      tests++; if ({mra, mwa, mrb, mwb} !== exp_en[i] || rwb !== (i == 2) || rww !== (i == 0)) begin
        failed++; $display("FAIL mem_enables[op%0d]: got ra=%0b wa=%0b rb=%0b wb=%0b rww=%0b rwb=%0b want %4b", 24 + i, mra, mwa, mrb, mwb, rww, rwb, exp_en[i]);
      end
      tests++; if ({out_valid, wb, alu_src, alu_opcode, reg1, reg2, reg3, im_data} !== {3'b101, 5'd1, 5'd10, 5'd9, 5'd9, 32'd4}) begin
        failed++; $display("FAIL mem_fields[op%0d]: got v=%0b wb=%0b src=%0b alu=%0d r1=%0d r2=%0d r3=%0d im=%0h want 1/0/1/1/10/9/9/4",
                           24 + i, out_valid, wb, alu_src, alu_opcode, reg1, reg2, reg3, im_data);
      end
    end
    in_valid = 0; step();
    tests++; if ({out_valid, mwb} !== 2'b00 || retired_count !== 4'd7) begin
      failed++; $display("FAIL mem_after: got v=%0b mwb=%0b cnt=%0d want 0/0/7", out_valid, mwb, retired_count);
    end
  endtask

  task automatic test_halt();
    instruction = 32'd0; in_valid = 1; out_ready = 1;
    step();
    instruction = {6'd3, 5'd4, 5'd5, 5'd6, 5'd0, 6'd0};
    #1;
    tests++; if ({out_valid, state, PC_enable, in_ready} !== {1'b0, 2'd1, 2'b00}) begin
      failed++; $display("FAIL halt_enter: got v=%0b st=%0d pc=%0b rdy=%0b want 0/1/0/0", out_valid, state, PC_enable, in_ready);
    end
    step(); step();
    tests++; if ({out_valid, retired_count} !== {1'b0, 4'd7}) begin
      failed++; $display("FAIL halt_blocked: got v=%0b cnt=%0d want 0/7", out_valid, retired_count);
    end
    resume = 1; step(); resume = 0;
    tests++; if ({state, in_ready, PC_enable} !== {2'd0, 2'b11}) begin
      failed++; $display("FAIL halt_resume: got st=%0d rdy=%0b pc=%0b want 0/1/1", state, in_ready, PC_enable);
    end
    step(); in_valid = 0;
    tests++; if ({out_valid, alu_opcode, retired_count} !== {1'b1, 5'd3, 4'd8}) begin
      failed++; $display("FAIL halt_next: got v=%0b alu=%0d cnt=%0d want 1/3/8", out_valid, alu_opcode, retired_count);
    end
  endtask

  task automatic test_control();
    logic [1:0] exp_j [4];
    logic [4:0] exp_a [4];
    exp_j[0] = 2'd3; exp_j[1] = 2'd2; exp_j[2] = 2'd1; exp_j[3] = 2'd1;
    exp_a[0] = 5'd0; exp_a[1] = 5'd0; exp_a[2] = 5'd16; exp_a[3] = 5'd15;
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      instruction = {6'(28 + i), 5'd6, 5'd8, 16'h8001};
      step();
      tests++; if ({jump_mux_signal, alu_opcode, wb, rww, reg1, reg2, reg3, im_data} !== {exp_j[i], exp_a[i], 2'b10, 5'd6, 5'd8, 5'd0, 32'hFFFF_8001}) begin
        failed++; $display("FAIL ctrl[op%0d]: got j=%0d alu=%0d wb=%0b rww=%0b r1=%0d r2=%0d r3=%0d im=%0h want j=%0d alu=%0d",
                           28 + i, jump_mux_signal, alu_opcode, wb, rww, reg1, reg2, reg3, im_data, exp_j[i], exp_a[i]);
      end
    end
    in_valid = 0; step();
  endtask

  task automatic test_cop_trap();
    instruction = {6'd40, 5'd1, 5'd2, 5'd3, 5'd4, 6'd0}; in_valid = 1; out_ready = 1;
    cop_flag_valid = 1; of_f = 1;
    step();
    cop_flag_valid = 0; of_f = 0;
    tests++; if ({out_valid, cop_sel, rww, wb, alu_opcode, reg3, reg1, reg2, s_r_amount, im_data} !==
                 {4'b1101, 5'd8, 5'd1, 5'd2, 5'd3, 5'd4, 32'h0000_1900}) begin
      failed++; $display("FAIL cop_bundle: got v=%0b cop=%0b rww=%0b wb=%0b alu=%0d r3=%0d r1=%0d r2=%0d sh=%0d im=%0h",
                         out_valid, cop_sel, rww, wb, alu_opcode, reg3, reg1, reg2, s_r_amount, im_data);
    end
    tests++; if ({state, exc_cause, in_ready, PC_enable, retired_count} !== {2'd2, 4'b0100, 2'b00, 4'd13}) begin
      failed++; $display("FAIL cop_trap: got st=%0d exc=%4b rdy=%0b pc=%0b cnt=%0d want 2/0100/0/0/13", state, exc_cause, in_ready, PC_enable, retired_count);
    end
    resume = 1; step(); resume = 0; in_valid = 0;
    tests++; if ({out_valid, state} !== {1'b0, 2'd2}) begin
      failed++; $display("FAIL trap_resume_ignored: got v=%0b st=%0d want 0/2", out_valid, state);
    end
    exc_clear = 1; step(); exc_clear = 0;
    tests++; if ({state, exc_cause} !== {2'd0, 4'd0}) begin
      failed++; $display("FAIL trap_clear: got st=%0d exc=%4b want 0/0000", state, exc_cause);
    end
    // flag report in the same cycle as a clear: new flag is kept
    cop_flag_valid = 1; nan_f = 1; exc_clear = 1; step();
    cop_flag_valid = 0; nan_f = 0;
    tests++; if ({state, exc_cause} !== {2'd2, 4'b0001}) begin
      failed++; $display("FAIL set_beats_clear: got st=%0d exc=%4b want 2/0001", state, exc_cause);
    end
    step(); exc_clear = 0;
    tests++; if ({state, exc_cause} !== {2'd0, 4'd0}) begin
      failed++; $display("FAIL second_clear: got st=%0d exc=%4b want 0/0000", state, exc_cause);
    end
  endtask

  task automatic test_saturation_and_reset();
    int exp_cnt;
    exp_cnt = 13;
    instruction = {6'd5, 5'd2, 5'd3, 5'd4, 5'd0, 6'd0}; in_valid = 1; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      tests++; if (retired_count !== 4'(exp_cnt)) begin
        failed++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, retired_count, exp_cnt);
      end
    end
    out_ready = 0; step(); step();
    tests++; if ({out_valid, in_ready, retired_count} !== {2'b10, 4'hF}) begin
      failed++; $display("FAIL sat_stall: got v=%0b rdy=%0b cnt=%0d want 1/0/15", out_valid, in_ready, retired_count);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if ({out_valid, in_ready, PC_enable, state, retired_count, reg3, rww, alu_opcode} !== {3'b011, 2'd0, 4'd0, 5'd0, 1'b0, 5'd0}) begin
      failed++; $display("FAIL async_reset: got v=%0b rdy=%0b pc=%0b st=%0d cnt=%0d r3=%0d rww=%0b alu=%0d want 0/1/1/0/0/0/0/0",
                         out_valid, in_ready, PC_enable, state, retired_count, reg3, rww, alu_opcode);
    end
    in_valid = 0;
    step(); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_stall();
    test_mem_back_to_back();
    test_halt();
    test_control();
    test_cop_trap();
    test_saturation_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_pipe_unit.md
Name: decode_pipe_unit

Overview:
- Registered instruction-decode stage: successor to the single-cycle control decoder.
- Adds a valid/ready handshake on both sides, a HALT/TRAP state machine driven by opcode 0 and coprocessor exception flags, sticky exception cause, parametrised immediate width and a retired-instruction counter.
- Sits between instruction fetch and the register file/ALU/coprocessor issue.
- All decode outputs, including write/memory enables, are registered and qualified by out_valid.

Parameters:
- DATA_W, 32, width of sign-extended immediate im_data (must be >= 16).
- CNT_W, 16, width of retired-instruction counter (saturating).
- TRAP_ON_COP, 1, 1 = coprocessor flags trap the decoder; 0 = flags only recorded in exc_cause.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instruction  in  32  instruction word; opcode = [31:26]
- in_valid  in  1  instruction presented
- in_ready  out  1  decoder can accept
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- reg1, reg2, reg3  out  5 each  source/destination register addresses
- s_r_amount  out  5  shift amount
- im_data  out  DATA_W  sign-extended instruction[15:0]
- alu_opcode  out  5  ALU/coprocessor operation
- jump_mux_signal  out  2  0 = pc+4, 1 = pc+imm, 2 = reg1, 3 = absolute
- write_back_on_register_mux_signal  out  1  1 = ALU result, 0 = memory
- alu_input_mux_signal  out  1  1 = immediate operand
- alu_or_coprocessor_mux_signal  out  1  1 = coprocessor result
- register_write_word_enable, register_write_byte_enable  out  1 each
- memwrite_enable_a, memwrite_enable_b, memread_enable_a, memread_enable_b  out  1 each  (a = word, b = byte)
- PC_enable  out  1  fetch may advance
- coP_NaN_flag, coP_UF_flag, coP_OF_flag, coP_Division_by_zero_flag  in  1 each
- cop_flag_valid  in  1  flags are meaningful this cycle
- exc_cause  out  4  sticky {DivZero, OF, UF, NaN}
- exc_clear  in  1  clears exc_cause and leaves TRAP
- resume  in  1  leaves HALT
- state  out  2  0 = RUN, 1 = HALT, 2 = TRAP
- retired_count  out  CNT_W  accepted non-halt instructions

Behaviour:
- Reset: every output is 0 except in_ready = 1 and PC_enable = 1. State = RUN.
- in_ready (combinational) = (state == RUN) && (!out_valid || out_ready). PC_enable = (state == RUN).
- Accept = in_valid && in_ready. On accept with opcode != 0:
  - Bundle is registered next edge and out_valid = 1 (latency 1).
  - retired_count increments, saturating at all-ones.
- out_valid && !out_ready: bundle and out_valid hold stable.
- out_ready with no accept: out_valid = 0 next edge and all enables = 0. Other fields hold their last value.
- Back-to-back accepts: one per cycle with out_ready held high.
- Decode classes:
  - Any field not listed for a class is driven 0 (never z).
  - im_data = {(DATA_W-16){instruction[15]}, instruction[15:0]} for all classes except 1-15.
- Opcode 1-15 (R-type):
  - reg3 = [25:21], reg1 = [20:16], reg2 = [15:11], s_r_amount = [10:6].
  - alu_opcode = [30:26]. wb = 1, alu_src = 0, cop = 0, reg_we_word = 1.
- Opcode 16-23 (I-type):
  - reg3 = [25:21], reg1 = [20:16]. wb = 1, alu_src = 1, reg_we_word = 1.
  - alu_opcode by [29:26]: 2→1, 3→2, 4→3, 5→4, 6→9, 7→10, else 0.
- Opcode 24-27 (memory):
  - reg1 = [20:16], reg2 = reg3 = [25:21]. alu_opcode = 1, alu_src = 1, wb = 0.
  - 24: reg_we_word + memread_a. 25: memwrite_a. 26: reg_we_byte + memread_b. 27: memwrite_b.
- Opcode 28-31 (control flow):
  - reg1 = [25:21], reg2 = [20:16]. wb = 1.
  - jump: 28→3, 29→2, 30/31→1.
  - alu_opcode: 30→16, 31→15, 28/29→0.
- Opcode 32-63 (coprocessor):
  - As R-type, but cop = 1 and reg_we_word = 0.
- Opcode 0 accepted:
  - No bundle is produced (out_valid is not set by it) and retired_count does not change.
  - State → HALT next edge.
- FSM transitions:
  - RUN→HALT: on opcode 0 accept.
  - RUN→TRAP: on cop_flag_valid && any flag && TRAP_ON_COP.
  - HALT→RUN: on resume.
  - TRAP→RUN: on exc_clear.
  - In HALT and TRAP: in_ready = 0, PC_enable = 0. A pending out_valid bundle still drains normally.
- exc_cause:
  - Sets when cop_flag_valid is high: OR of the flags, in any state and for either TRAP_ON_COP value.
  - Clears on exc_clear. If set and clear occur in the same cycle, set wins: new flags are recorded, and state leaves TRAP.
- Simultaneous events:
  - Accept and trap in the same cycle: the instruction is decoded and issued, then state → TRAP.
  - Halt-opcode accept and trap in the same cycle: TRAP has priority.
  - resume while in TRAP: ignored.
- Reset mid-bundle: out_valid drops immediately (async) and the bundle is discarded.

Test Plan:
- After rst, send 0x0462_2800 (opcode 1, rd=3, rs=2, rt=5) with out_ready = 1 → next cycle out_valid = 1, reg3 = 3, reg1 = 2, reg2 = 5, alu_opcode = 1, reg_we_word = 1, retired_count = 1.
- Send I-type opcode 18 with imm 0xFFF0 and DATA_W = 32 → im_data = 0xFFFF_FFF0, alu_opcode = 1, alu_src = 1. Hold out_ready = 0 for 3 cycles → bundle stable and in_ready = 0. Then release → next instruction accepted.
- Send opcodes 24, 25, 26, 27 back-to-back → exactly one of memread_a / memwrite_a / memread_b+reg_we_byte / memwrite_b per bundle. wb = 0 for all four.
- Send opcode 0 → no out_valid, state = 1, PC_enable = 0, in_ready = 0 despite in_valid. Pulse resume → state = 0 and the next instruction is accepted. retired_count is unchanged by the halt.
- With TRAP_ON_COP = 1, pulse cop_flag_valid with OF = 1 in the same cycle as an accept → bundle issued, then state = 2 and exc_cause = 4'b0100. Pulse exc_clear → state = 0, exc_cause = 0.
- Preset counter to saturation (CNT_W = 4, 16 accepts) → retired_count stays 4'hF. Assert rst mid-stall → all outputs return to reset values asynchronously.
